operand_loader: RTL

Front-end stage for `computation_module`. It accepts a byte stream made of one header byte, 16 A-matrix bytes and 9 B-kernel bytes, and holds them as stable parallel operands `a11..a44` and `b11..b33`. It then runs the `active_send`/`done_send` handshake, asserts the selected engine's `active_*` until the matching `done_*` arrives, and captures the 2×2 result into a ready/valid output register.

---
 rtl/computation_pkg.sv | 26 ++
 rtl/operand_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/computation_pkg.sv
// Shared definitions for the operand loader and the computation stage:
// mode encodings, operand byte counts and the loader state enum.
package computation_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_SA3    = 2'b10;
    localparam logic [1:0] MODE_SA2    = 2'b11;

    localparam int A_BYTES = 16;
    localparam int B_BYTES = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_SEND   = 3'd3,
        ST_RUN    = 3'd4,
        ST_RESULT = 3'd5
    } load_state_e;

    // A header is valid when the upper six bits are clear and a mode is selected.
    function automatic logic header_valid(input logic [7:0] hdr);
        return (hdr[7:2] == 6'd0) && (hdr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/operand_loader.sv
// Byte-stream front end for computation_module: parses a header, loads the
// 4x4 A matrix and 3x3 B kernel into stable operand registers, runs the
// send/compute handshakes and holds the 2x2 result behind ready/valid.
module operand_loader
    import computation_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] a11, output logic [7:0] a12, output logic [7:0] a13, output logic [7:0] a14,
    output logic [7:0] a21, output logic [7:0] a22, output logic [7:0] a23, output logic [7:0] a24,
    output logic [7:0] a31, output logic [7:0] a32, output logic [7:0] a33, output logic [7:0] a34,
    output logic [7:0] a41, output logic [7:0] a42, output logic [7:0] a43, output logic [7:0] a44,
    output logic [7:0] b11, output logic [7:0] b12, output logic [7:0] b13,
    output logic [7:0] b21, output logic [7:0] b22, output logic [7:0] b23,
    output logic [7:0] b31, output logic [7:0] b32, output logic [7:0] b33,
    output logic       active_send,
    output logic       active_single,
    output logic       active_sa3,
    output logic       active_sa2,
    input  logic       done_send,
    input  logic       done_single,
    input  logic       done_sa3,
    input  logic       done_sa2,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    output logic [7:0] r11,
    output logic [7:0] r12,
    output logic [7:0] r21,
    output logic [7:0] r22,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       err,
    output logic       busy
);

    localparam logic [4:0] A_LAST = 5'(A_BYTES - 1);
    localparam logic [4:0] B_LAST = 5'(B_BYTES - 1);

    load_state_e state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  mode_q;
    logic        err_q;
    logic [7:0]  r_q [4];
    logic [7:0]  a_q [A_BYTES];
    logic [7:0]  b_q [B_BYTES];

    logic               accept;
    logic               a_load;
    logic               b_load;
    logic               mode_done;
    logic [A_BYTES-1:0] a_we;
    logic [B_BYTES-1:0] b_we;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign accept   = in_valid & in_ready;
    assign a_load   = accept && (state_q == ST_LOAD_A);
    assign b_load   = accept && (state_q == ST_LOAD_B);

    // Per-slot write enables: each operand register owns one counter value.
    genvar gi;
    generate
        for (gi = 0; gi < A_BYTES; gi++) begin : g_a_we
            localparam logic [4:0] IDX = 5'(gi);
            assign a_we[gi] = a_load && (cnt_q == IDX);
        end
        for (gi = 0; gi < B_BYTES; gi++) begin : g_b_we
            localparam logic [4:0] IDX = 5'(gi);
            assign b_we[gi] = b_load && (cnt_q == IDX);
        end
    endgenerate

    // Completion from the engine chosen by the latched mode; other dones are ignored.
    always_comb begin
        mode_done = 1'b0;
        case (mode_q)
            MODE_SINGLE: mode_done = done_single;
            MODE_SA3:    mode_done = done_sa3;
            MODE_SA2:    mode_done = done_sa2;
            default:     mode_done = 1'b0;
        endcase
    end

    // Operand registers: written only while loading, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < A_BYTES; i++) a_q[i] <= '0;
            for (int i = 0; i < B_BYTES; i++) b_q[i] <= '0;
        end else begin
            for (int i = 0; i < A_BYTES; i++) if (a_we[i]) a_q[i] <= in_data;
            for (int i = 0; i < B_BYTES; i++) if (b_we[i]) b_q[i] <= in_data;
        end
    end

    // Loader FSM with byte counter, mode latch, error pulse and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (header_valid(in_data)) begin
                            mode_q  <= in_data[1:0];
                            cnt_q   <= '0;
                            state_q <= ST_LOAD_A;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD_A: begin
                    if (accept) begin
                        if (cnt_q == A_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_LOAD_B;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (accept) begin
                        if (cnt_q == B_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_SEND;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                ST_SEND: begin
                    if (done_send) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (mode_done) begin
                        r_q[0]  <= c11;
                        r_q[1]  <= c12;
                        r_q[2]  <= c21;
                        r_q[3]  <= c22;
                        state_q <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Control outputs decoded purely from registered state.
    assign active_send   = (state_q == ST_SEND);
    assign active_single = (state_q == ST_RUN) && (mode_q == MODE_SINGLE);
    assign active_sa3    = (state_q == ST_RUN) && (mode_q == MODE_SA3);
    assign active_sa2    = (state_q == ST_RUN) && (mode_q == MODE_SA2);
    assign res_valid     = (state_q == ST_RESULT);
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

    assign r11 = r_q[0];
    assign r12 = r_q[1];
    assign r21 = r_q[2];
    assign r22 = r_q[3];

    assign a11 = a_q[0];  assign a12 = a_q[1];  assign a13 = a_q[2];  assign a14 = a_q[3];
    assign a21 = a_q[4];  assign a22 = a_q[5];  assign a23 = a_q[6];  assign a24 = a_q[7];
    assign a31 = a_q[8];  assign a32 = a_q[9];  assign a33 = a_q[10]; assign a34 = a_q[11];
    assign a41 = a_q[12]; assign a42 = a_q[13]; assign a43 = a_q[14]; assign a44 = a_q[15];

    assign b11 = b_q[0]; assign b12 = b_q[1]; assign b13 = b_q[2];
    assign b21 = b_q[3]; assign b22 = b_q[4]; assign b23 = b_q[5];
    assign b31 = b_q[6]; assign b32 = b_q[7]; assign b33 = b_q[8];

endmodule
